mem_byte_ctrl: RTL and testbench

Memory-access unit behind the MEM stage. It serialises byte, half and word loads and stores onto the single 8-bit RAM port. It is the requesting end of the pipeline stall protocol: it raises `mem_req` toward the stall controller while an access is in flight, and drops it in the cycle the result is valid, so the MEM-stage instruction retires exactly once.

---
 rtl/mem_byte_ctrl_pkg.sv | 25 ++
 rtl/mem_byte_ctrl_load_ext.sv | 19 +
 rtl/mem_byte_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_byte_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_byte_ctrl_pkg.sv
// Shared constants, size codes and FSM state encoding for the byte-serial memory access unit.
package mem_byte_ctrl_pkg;

   localparam logic RstEnable = 1'b1;

   localparam logic [1:0] SizeByte = 2'b00;
   localparam logic [1:0] SizeHalf = 2'b01;
   localparam logic [1:0] SizeWord = 2'b10;

   typedef enum logic [1:0] {
      MbcIdle = 2'd0,
      MbcBusy = 2'd1,
      MbcDone = 2'd2
   } mbc_state_e;

   // Size code 11 is handled as a word access.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SizeByte: return 3'd1;
         SizeHalf: return 3'd2;
         default:  return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_byte_ctrl_load_ext.sv
// Load result extension: sign- or zero-extends a byte/half from the low lanes of raw.
module load_ext
   import mem_byte_ctrl_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] rdata
);

   always_comb begin
      case (size)
         SizeByte: rdata = {{24{sign & raw[7]}}, raw[7:0]};
         SizeHalf: rdata = {{16{sign & raw[15]}}, raw[15:0]};
         default:  rdata = raw;
      endcase
   end

endmodule

// File: rtl/mem_byte_ctrl.sv
// Serialises byte/half/word loads and stores onto an 8-bit RAM port and stalls the pipeline meanwhile.
// Optional MEM_MISALIGN_TRAP_EN adds mem_misalign and short-circuits misaligned half/word accesses.
module mem_byte_ctrl
   import mem_byte_ctrl_pkg::*;
#(
   parameter int RD_LAT = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_re,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [1:0]  mem_size,
   input  logic        mem_sign,
   output logic        mem_req,
   output logic [31:0] mem_rdata,
   output logic        mem_done,
   output logic [31:0] ram_addr,
   output logic [7:0]  ram_dout,
   output logic        ram_wr,
   input  logic [7:0]  ram_din
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic        mem_misalign
`endif
);

   localparam logic [2:0] RdLat = 3'(RD_LAT);

   mbc_state_e  state;
   mbc_state_e  next_state;
   logic [2:0]  cnt;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [1:0]  lat_size;
   logic        lat_sign;
   logic        lat_wr;
   logic        lat_trap;
   logic [31:0] asm_data;
   logic [31:0] rdata_hold;

   logic        request;
   logic        trap_now;
   logic [2:0]  nbytes;
   logic [2:0]  last_cnt;
   logic [2:0]  offset;
   logic [1:0]  lane;
   logic [31:0] ext_rdata;
   logic [31:0] done_rdata;

   assign request = mem_re | mem_we;

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap_now = ((mem_size == SizeHalf) && mem_addr[0]) ||
                     ((mem_size != SizeByte) && (mem_size != SizeHalf) && (mem_addr[1:0] != 2'b00));
`else
   assign trap_now = 1'b0;
`endif

   // Loads keep counting RD_LAT drain cycles past the last issued address.
   assign nbytes     = size_bytes(lat_size);
   assign last_cnt   = lat_wr ? (nbytes - 3'd1) : (nbytes - 3'd1 + RdLat);
   assign offset     = (cnt < nbytes) ? cnt : (nbytes - 3'd1);
   assign lane       = 2'(cnt - RdLat);
   assign done_rdata = lat_trap ? 32'h0 : ext_rdata;

   load_ext u_load_ext (
      .raw   (asm_data),
      .size  (lat_size),
      .sign  (lat_sign),
      .rdata (ext_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst == RstEnable) state <= MbcIdle;
      else                  state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         MbcIdle: if (request) next_state = trap_now ? MbcDone : MbcBusy;
         MbcBusy: if (cnt == last_cnt) next_state = MbcDone;
         MbcDone: next_state = MbcIdle;
         default: next_state = MbcIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         cnt        <= 3'd0;
         lat_addr   <= 32'h0;
         lat_wdata  <= 32'h0;
         lat_size   <= 2'b00;
         lat_sign   <= 1'b0;
         lat_wr     <= 1'b0;
         lat_trap   <= 1'b0;
         asm_data   <= 32'h0;
         rdata_hold <= 32'h0;
      end else begin
         case (state)
            MbcIdle: if (request) begin
               cnt       <= 3'd0;
               lat_addr  <= mem_addr;
               lat_wdata <= mem_wdata;
               lat_size  <= mem_size;
               lat_sign  <= mem_sign;
               lat_wr    <= mem_we;
               lat_trap  <= trap_now;
               asm_data  <= 32'h0;
            end
            MbcBusy: begin
               cnt <= cnt + 3'd1;
               if (!lat_wr && (cnt >= RdLat))
                  asm_data[{lane, 3'b000} +: 8] <= ram_din;
            end
            MbcDone: rdata_hold <= done_rdata;
            default: ;
         endcase
      end
   end

   // A write already on the port in the reset cycle completes; the stall and result go quiet at once.
   always_comb begin
      mem_req   = 1'b0;
      mem_done  = 1'b0;
      mem_rdata = rdata_hold;
      ram_addr  = 32'h0;
      ram_dout  = 8'h0;
      ram_wr    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign = 1'b0;
`endif
      case (state)
         MbcIdle: mem_req = request;
         MbcBusy: begin
            mem_req  = 1'b1;
            ram_addr = lat_addr + 32'(offset);
            if (lat_wr) begin
               ram_wr   = 1'b1;
               ram_dout = lat_wdata[{cnt[1:0], 3'b000} +: 8];
            end
         end
         MbcDone: begin
            mem_done  = 1'b1;
            mem_rdata = done_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
            mem_misalign = lat_trap;
`endif
         end
         default: ;
      endcase
      if (rst == RstEnable) begin
         mem_req   = 1'b0;
         mem_done  = 1'b0;
         mem_rdata = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
         mem_misalign = 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Directed bench for mem_byte_ctrl: one instance with RD_LAT=1, one with RD_LAT=2, each with its own RAM model.
// Also covers the MEM_MISALIGN_TRAP_EN build when that macro is defined.
module tb_mem_byte_ctrl;

   logic        clk;
   logic        rst;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_size;
   logic        mem_sign;

   logic        mem_req_a, mem_done_a, ram_wr_a;
   logic [31:0] mem_rdata_a, ram_addr_a;
   logic [7:0]  ram_dout_a, ram_din_a;
   logic        mem_req_b, mem_done_b, ram_wr_b;
   logic [31:0] mem_rdata_b, ram_addr_b;
   logic [7:0]  ram_dout_b, ram_din_b, ram_stage_b;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        mem_misalign_a, mem_misalign_b;
`endif

   logic [7:0] ram_a [bit [31:0]];
   logic [7:0] ram_b [bit [31:0]];

   int vectors = 0;
   int errors  = 0;

   int          req_a, req_b, done_a, done_b, wr_n, mis_a;
   logic [31:0] rd_a, rd_b;
   logic [31:0] wr_addr [8];
   logic [7:0]  wr_dout [8];
   logic [31:0] addr_log [24];

   mem_byte_ctrl #(.RD_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_sign(mem_sign), .mem_req(mem_req_a),
      .mem_rdata(mem_rdata_a), .mem_done(mem_done_a), .ram_addr(ram_addr_a),
      .ram_dout(ram_dout_a), .ram_wr(ram_wr_a), .ram_din(ram_din_a)
`ifdef MEM_MISALIGN_TRAP_EN
      , .mem_misalign(mem_misalign_a)
`endif
   );

   mem_byte_ctrl #(.RD_LAT(2)) dut_b (
      .clk(clk), .rst(rst), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_sign(mem_sign), .mem_req(mem_req_b),
      .mem_rdata(mem_rdata_b), .mem_done(mem_done_b), .ram_addr(ram_addr_b),
      .ram_dout(ram_dout_b), .ram_wr(ram_wr_b), .ram_din(ram_din_b)
`ifdef MEM_MISALIGN_TRAP_EN
      , .mem_misalign(mem_misalign_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] peek_a(input logic [31:0] a);
      return ram_a.exists(a) ? ram_a[a] : 8'h00;
   endfunction

   function automatic logic [7:0] peek_b(input logic [31:0] a);
      return ram_b.exists(a) ? ram_b[a] : 8'h00;
   endfunction

   // RAM models: read data appears RD_LAT edges after the address.
   always @(posedge clk) begin
      ram_din_a   <= peek_a(ram_addr_a);
      ram_stage_b <= peek_b(ram_addr_b);
      ram_din_b   <= ram_stage_b;
      if (ram_wr_a) ram_a[ram_addr_a] = ram_dout_a;
      if (ram_wr_b) ram_b[ram_addr_b] = ram_dout_b;
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] d);
      ram_a[a] = d;
      ram_b[a] = d;
   endtask

   // Issues one access and samples both instances every cycle until both have signalled done.
   task automatic apply_stimulus(input logic re, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size, input logic sign);
      bit tail;
      @(negedge clk);
      mem_re = re; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_size = size; mem_sign = sign;
      req_a = 0; req_b = 0; done_a = 0; done_b = 0; wr_n = 0; mis_a = 0; tail = 0;
      rd_a = 32'hxxxxxxxx; rd_b = 32'hxxxxxxxx;
      for (int c = 0; c < 24; c++) begin
         #1;
         addr_log[c] = ram_addr_a;
         if (mem_req_a) req_a++;
         if (mem_req_b) req_b++;
         if (ram_wr_a) begin
            if (wr_n < 8) begin
               wr_addr[wr_n] = ram_addr_a;
               wr_dout[wr_n] = ram_dout_a;
            end
            wr_n++;
         end
         if (mem_done_a) begin done_a++; rd_a = mem_rdata_a; end
         if (mem_done_b) begin done_b++; rd_b = mem_rdata_b; end
`ifdef MEM_MISALIGN_TRAP_EN
         if (mem_misalign_a) mis_a++;
`endif
         if (tail) break;
         if (done_a > 0 && done_b > 0) tail = 1;
         @(negedge clk);
         if (c == 0) begin mem_re = 1'b0; mem_we = 1'b0; end
      end
   endtask

   initial begin
      int wr_after;
      rst = 1'b1; mem_re = 1'b1; mem_we = 1'b0; mem_addr = 32'h20; mem_wdata = 32'h0;
      mem_size = 2'b00; mem_sign = 1'b0;
      preload(32'h20, 8'h80);
      preload(32'hFFFFFFFF, 8'h34);
      preload(32'h0, 8'h12);
      preload(32'h40, 8'h01);
      preload(32'h41, 8'h80);
      preload(32'h104, 8'h5A);
      preload(32'h105, 8'h6B);
      for (int a = 32'h200; a < 32'h204; a++) preload(32'(a), 8'hEE);

      repeat (2) @(negedge clk);
      #1;
      check_output("rst mem_req", 32'(mem_req_a), 32'h0);
      check_output("rst mem_done", 32'(mem_done_a), 32'h0);
      check_output("rst ram_wr", 32'(ram_wr_a), 32'h0);
      check_output("rst ram_addr", ram_addr_a, 32'h0);
      check_output("rst mem_rdata", mem_rdata_a, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      check_output("rst mem_misalign", 32'(mem_misalign_a), 32'h0);
`endif
      mem_re = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      apply_stimulus(1'b0, 1'b1, 32'h100, 32'hA1B2C3D4, 2'b10, 1'b0);
      check_output("sw req cycles", 32'(req_a), 32'd5);
      check_output("sw req cycles lat2", 32'(req_b), 32'd5);
      check_output("sw done pulses", 32'(done_a), 32'd1);
      check_output("sw write count", 32'(wr_n), 32'd4);
      check_output("sw addr0", wr_addr[0], 32'h100);
      check_output("sw dout0", 32'(wr_dout[0]), 32'hD4);
      check_output("sw addr1", wr_addr[1], 32'h101);
      check_output("sw dout1", 32'(wr_dout[1]), 32'hC3);
      check_output("sw addr2", wr_addr[2], 32'h102);
      check_output("sw dout2", 32'(wr_dout[2]), 32'hB2);
      check_output("sw addr3", wr_addr[3], 32'h103);
      check_output("sw dout3", 32'(wr_dout[3]), 32'hA1);

      apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b1);
      check_output("lb signed", rd_a, 32'hFFFFFF80);
      check_output("lb signed req", 32'(req_a), 32'd3);
      check_output("lb signed lat2", rd_b, 32'hFFFFFF80);
      check_output("lb signed req lat2", 32'(req_b), 32'd4);

      apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b0);
      check_output("lb unsigned", rd_a, 32'h00000080);
      check_output("lb unsigned lat2", rd_b, 32'h00000080);

      apply_stimulus(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 2'b01, 1'b1);
      check_output("lh wrap data", rd_a, 32'h00001234);
      check_output("lh wrap addr0", addr_log[1], 32'hFFFFFFFF);
      check_output("lh wrap addr1", addr_log[2], 32'h00000000);
      check_output("lh drain addr hold", addr_log[3], 32'h00000000);
      check_output("lh wrap data lat2", rd_b, 32'h00001234);

      apply_stimulus(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b1);
      check_output("lw data", rd_a, 32'hA1B2C3D4);
      check_output("lw req", 32'(req_a), 32'd6);
      check_output("lw data lat2", rd_b, 32'hA1B2C3D4);
      check_output("lw req lat2", 32'(req_b), 32'd7);
      check_output("lw done lat2", 32'(done_b), 32'd1);
      check_output("lw rdata hold", mem_rdata_a, 32'hA1B2C3D4);

      apply_stimulus(1'b1, 1'b1, 32'h30, 32'hDEADBE77, 2'b00, 1'b0);
      check_output("sb req", 32'(req_a), 32'd2);
      check_output("sb write count", 32'(wr_n), 32'd1);
      check_output("sb dout", 32'(wr_dout[0]), 32'h77);
      check_output("sb ram", 32'(peek_a(32'h30)), 32'h77);

      apply_stimulus(1'b1, 1'b0, 32'h40, 32'h0, 2'b01, 1'b1);
      check_output("lh signed neg", rd_a, 32'hFFFF8001);
      apply_stimulus(1'b1, 1'b0, 32'h40, 32'h0, 2'b01, 1'b0);
      check_output("lh unsigned", rd_b, 32'h00008001);
      apply_stimulus(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0);
      check_output("size11 word", rd_a, 32'hA1B2C3D4);

      apply_stimulus(1'b1, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
      check_output("trap req", 32'(req_a), 32'd1);
      check_output("trap misalign", 32'(mis_a), 32'd1);
      check_output("trap done", 32'(done_a), 32'd1);
      check_output("trap rdata", rd_a, 32'h0);
      check_output("trap no ram addr", addr_log[1], 32'h0);
`else
      check_output("unaligned lw data", rd_a, 32'h6B5AA1B2);
      check_output("unaligned lw req", 32'(req_a), 32'd6);
      check_output("unaligned lw lat2", rd_b, 32'h6B5AA1B2);
`endif

      // Reset during the second BUSY cycle of a word store.
      @(negedge clk);
      mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h11223344; mem_size = 2'b10;
      #1;
      check_output("abort idle req", 32'(mem_req_a), 32'd1);
      @(negedge clk);
      mem_we = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("abort mem_req", 32'(mem_req_a), 32'd0);
      wr_after = 0;
      for (int c = 0; c < 4; c++) begin
         if (ram_wr_a || ram_wr_b) wr_after++;
         @(negedge clk);
         #1;
      end
      check_output("abort no writes", 32'(wr_after), 32'd0);
      check_output("abort byte0", 32'(peek_a(32'h200)), 32'h44);
      check_output("abort byte1", 32'(peek_a(32'h201)), 32'h33);
      check_output("abort byte2", 32'(peek_a(32'h202)), 32'hEE);
      check_output("abort byte3", 32'(peek_a(32'h203)), 32'hEE);

      apply_stimulus(1'b1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b0);
      check_output("post abort lb", rd_a, 32'h00000080);
      check_output("post abort req", 32'(req_a), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
